// File: rtl/barrel_shifter_pkg.sv
// barrel_shifter_pkg: op encoding and direction constants shared by pipelined_barrel_shifter and shift_stage
package barrel_shifter_pkg;
    typedef enum logic [1:0] {
        SH_LOGIC = 2'd0,
        SH_ROT   = 2'd1,
        SH_ARITH = 2'd2,
        SH_PASS  = 2'd3
    } shift_op_e;
    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;
endpackage

// File: rtl/pipelined_barrel_shifter_stage.sv
// shift_stage: one registered 2**STAGE shift slot with valid/ready; carry and zero flags under BARREL_SHIFTER_FLAGS_EN
module shift_stage
    import barrel_shifter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SH_W  = $clog2(WIDTH),
    parameter int STAGE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SH_W-1:0]  in_shamt,
    input  logic             in_dir,
    input  shift_op_e        in_op,
`ifdef BARREL_SHIFTER_FLAGS_EN
    input  logic             in_carry,
    output logic             out_carry,
    output logic             out_zero,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [SH_W-1:0]  out_shamt,
    output logic             out_dir,
    output shift_op_e        out_op
);
    localparam int AMT = 1 << STAGE;
    logic             act;
    logic [WIDTH-1:0] fill_r, fill_l, nxt;
    always_comb begin
        act    = in_shamt[STAGE] && in_op != SH_PASS;
        fill_r = in_op == SH_ROT ? in_data << (WIDTH - AMT) :
                 in_op == SH_ARITH ? {WIDTH{in_data[WIDTH-1]}} << (WIDTH - AMT) : '0;
        fill_l = in_op == SH_ROT ? in_data >> (WIDTH - AMT) : '0;
        nxt    = !act ? in_data :
                 in_dir == DIR_RIGHT ? (in_data >> AMT) | fill_r : (in_data << AMT) | fill_l;
    end
`ifdef BARREL_SHIFTER_FLAGS_EN
    logic nxt_carry;
    assign nxt_carry = !act ? in_carry : in_dir == DIR_LEFT ? in_data[WIDTH-AMT] : in_data[AMT-1];
`endif
    assign in_ready = !out_valid || out_ready;
    // Zero flag only matters on the final stage; earlier copies stay constant 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_shamt <= '0;
            out_dir   <= DIR_RIGHT;
            out_op    <= SH_LOGIC;
`ifdef BARREL_SHIFTER_FLAGS_EN
            out_carry <= 1'b0;
            out_zero  <= 1'b0;
`endif
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data  <= nxt;
                out_shamt <= in_shamt;
                out_dir   <= in_dir;
                out_op    <= in_op;
`ifdef BARREL_SHIFTER_FLAGS_EN
                out_carry <= nxt_carry;
                if (STAGE == SH_W - 1)
                    out_zero <= nxt == '0;
`endif
            end
        end
    end
endmodule

// File: rtl/pipelined_barrel_shifter.sv
// pipelined_barrel_shifter: log2(WIDTH)-stage shift/rotate/arith/pass pipeline with valid/ready; BARREL_SHIFTER_FLAGS_EN adds out_carry/out_zero
module pipelined_barrel_shifter
    import barrel_shifter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SH_W  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SH_W-1:0]  in_shamt,
    input  logic             in_dir,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef BARREL_SHIFTER_FLAGS_EN
    ,
    output logic             out_carry,
    output logic             out_zero
`endif
);
    logic             vld   [SH_W+1];
    logic             rdy   [SH_W+1];
    logic [WIDTH-1:0] data  [SH_W+1];
    logic [SH_W-1:0]  shamt [SH_W+1];
    logic             dir   [SH_W+1];
    shift_op_e        op    [SH_W+1];
`ifdef BARREL_SHIFTER_FLAGS_EN
    logic             carry [SH_W+1];
    logic             zero  [SH_W];
    assign carry[0]  = 1'b0;
    assign out_carry = carry[SH_W];
    assign out_zero  = zero[SH_W-1];
`endif
    assign vld[0]    = in_valid;
    assign data[0]   = in_data;
    assign shamt[0]  = in_shamt;
    assign dir[0]    = in_dir;
    assign op[0]     = shift_op_e'(in_op);
    assign rdy[SH_W] = out_ready;
    assign in_ready  = rdy[0];
    assign out_valid = vld[SH_W];
    assign out_data  = data[SH_W];
    for (genvar k = 0; k < SH_W; k++) begin : g_stage
        shift_stage #(.WIDTH(WIDTH), .SH_W(SH_W), .STAGE(k)) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (vld[k]),
            .in_ready (rdy[k]),
            .in_data  (data[k]),
            .in_shamt (shamt[k]),
            .in_dir   (dir[k]),
            .in_op    (op[k]),
`ifdef BARREL_SHIFTER_FLAGS_EN
            .in_carry (carry[k]),
            .out_carry(carry[k+1]),
            .out_zero (zero[k]),
`endif
            .out_valid(vld[k+1]),
            .out_ready(rdy[k+1]),
            .out_data (data[k+1]),
            .out_shamt(shamt[k+1]),
            .out_dir  (dir[k+1]),
            .out_op   (op[k+1])
        );
    end
endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// tb_pipelined_barrel_shifter: vector table, latency, backpressure, async reset and random scoreboard checks
module tb_pipelined_barrel_shifter;
    localparam int WIDTH = 8;
    localparam int SH_W  = 3;
    typedef struct packed {logic [WIDTH-1:0] data; logic carry;} res_t;
    typedef struct {
        logic [7:0] data; logic [2:0] shamt; logic dir; logic [1:0] op;
        logic [7:0] exp_data; logic exp_carry;
    } vec_t;
    logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_dir = 1'b0, out_ready = 1'b0;
    logic in_ready, out_valid;
    logic [WIDTH-1:0] in_data = '0, out_data;
    logic [SH_W-1:0]  in_shamt = '0;
    logic [1:0]       in_op = '0;
`ifdef BARREL_SHIFTER_FLAGS_EN
    logic out_carry, out_zero;
`endif
    res_t cur_exp, popped, sb[$];
    int errors = 0, checks = 0;
    logic stall_q = 1'b0;
    logic [WIDTH-1:0] held_q = '0;
    vec_t vecs[16];
    always #5 clk = ~clk;
    pipelined_barrel_shifter #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_shamt(in_shamt), .in_dir(in_dir), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef BARREL_SHIFTER_FLAGS_EN
        , .out_carry(out_carry), .out_zero(out_zero)
`endif
    );
    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    function automatic res_t model(input logic [7:0] d, input int s, input logic dir, input logic [1:0] op);
        res_t r;
        r.data = d;
        r.carry = 1'b0;
        if (op == 2'd3 || s == 0) return r;
        if (dir) begin
            r.data = d << s;
            if (op == 2'd1) r.data = r.data | (d >> (WIDTH - s));
            r.carry = d[WIDTH-s];
        end else begin
            r.data = d >> s;
            if (op == 2'd1) r.data = r.data | (d << (WIDTH - s));
            if (op == 2'd2) r.data = $signed(d) >>> s;
            r.carry = d[s-1];
        end
        return r;
    endfunction
    // Scoreboard: pop/compare on output handshake, push on input handshake, hold check while stalled.
    always @(negedge clk) begin
        if (!rst_n) stall_q = 1'b0;
        else begin
            if (stall_q) begin
                check("hold_valid", {7'b0, out_valid}, 8'd1);
                check("hold_data", out_data, held_q);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_out: got %h expected no beat", out_data);
                end else begin
                    popped = sb.pop_front();
                    check("out_data", out_data, popped.data);
`ifdef BARREL_SHIFTER_FLAGS_EN
                    check("out_carry", {7'b0, out_carry}, {7'b0, popped.carry});
                    check("out_zero", {7'b0, out_zero}, {7'b0, out_data == '0});
`endif
                end
            end
            if (in_valid && in_ready) sb.push_back(cur_exp);
            stall_q = out_valid && !out_ready;
            held_q = out_data;
        end
    end
    task automatic drive(input logic [7:0] d, input logic [2:0] s, input logic dir, input logic [1:0] op, input res_t e);
        logic acc;
        in_valid = 1'b1; in_data = d; in_shamt = s; in_dir = dir; in_op = op; cur_exp = e;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
        checks++;
        errors++;
        $display("FAIL drive_timeout: got in_ready 0 expected 1");
    endtask
    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        check("drain_empty", 8'(sb.size()), 8'd0);
        @(posedge clk);
        #1;
    endtask
    task automatic set_beat(input int i);
        in_data = 8'h11 * 8'(i + 1); in_shamt = 3'(i); in_dir = i[0]; in_op = 2'(i);
        cur_exp = model(in_data, int'(in_shamt), in_dir, in_op);
    endtask
    initial begin
        int lat, acc, pops, sent;
        logic have;
        vecs[0]  = '{8'h96, 3'd3, 1'b1, 2'd0, 8'hB0, 1'b0};
        vecs[1]  = '{8'h96, 3'd2, 1'b0, 2'd0, 8'h25, 1'b1};
        vecs[2]  = '{8'h96, 3'd1, 1'b0, 2'd1, 8'h4B, 1'b0};
        vecs[3]  = '{8'h96, 3'd2, 1'b0, 2'd2, 8'hE5, 1'b1};
        vecs[4]  = '{8'hA5, 3'd0, 1'b0, 2'd0, 8'hA5, 1'b0};
        vecs[5]  = '{8'hA5, 3'd0, 1'b1, 2'd1, 8'hA5, 1'b0};
        vecs[6]  = '{8'hA5, 3'd0, 1'b0, 2'd2, 8'hA5, 1'b0};
        vecs[7]  = '{8'hA5, 3'd0, 1'b1, 2'd3, 8'hA5, 1'b0};
        vecs[8]  = '{8'hA5, 3'd7, 1'b0, 2'd3, 8'hA5, 1'b0};
        vecs[9]  = '{8'h00, 3'd1, 1'b1, 2'd0, 8'h00, 1'b0};
        vecs[10] = '{8'h80, 3'd1, 1'b1, 2'd2, 8'h00, 1'b1};
        vecs[11] = '{8'h83, 3'd7, 1'b1, 2'd1, 8'hC1, 1'b1};
        vecs[12] = '{8'h80, 3'd7, 1'b0, 2'd2, 8'hFF, 1'b0};
        vecs[13] = '{8'h7F, 3'd7, 1'b0, 2'd2, 8'h00, 1'b1};
        vecs[14] = '{8'h80, 3'd7, 1'b0, 2'd0, 8'h01, 1'b0};
        vecs[15] = '{8'hFF, 3'd4, 1'b0, 2'd1, 8'hFF, 1'b1};
        #1;
        check("reset_out_valid", {7'b0, out_valid}, 8'd0);
        check("reset_out_data", out_data, 8'h00);
        check("reset_in_ready", {7'b0, in_ready}, 8'd1);
`ifdef BARREL_SHIFTER_FLAGS_EN
        check("reset_out_carry", {7'b0, out_carry}, 8'd0);
        check("reset_out_zero", {7'b0, out_zero}, 8'd0);
`endif
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        // Latency: one beat into an empty pipe.
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 8'h96; in_shamt = 3'd3; in_dir = 1'b1; in_op = 2'd0;
        cur_exp = '{8'hB0, 1'b0};
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk);
            #1 lat++;
        end
        check("latency", 8'(lat), 8'd3);
        drain();
        foreach (vecs[i])
            drive(vecs[i].data, vecs[i].shamt, vecs[i].dir, vecs[i].op, '{vecs[i].exp_data, vecs[i].exp_carry});
        drain();
        // Backpressure: only SH_W beats fit while the consumer stalls.
        out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            in_valid = 1'b1;
            set_beat(acc);
            @(negedge clk);
            if (in_ready) acc++;
            @(posedge clk);
            #1;
        end
        check("bp_accepted_stalled", 8'(acc), 8'd3);
        check("bp_in_ready_full", {7'b0, in_ready}, 8'd0);
        out_ready = 1'b1;
        pops = 0;
        for (int c = 0; c < 5; c++) begin
            in_valid = acc < 5;
            if (acc < 5) set_beat(acc);
            @(negedge clk);
            if (c == 0) check("bp_full_pop_push", {7'b0, in_ready}, 8'd1);
            if (out_valid) pops++;
            if (in_valid && in_ready) acc++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("bp_accepted_total", 8'(acc), 8'd5);
        check("bp_pops_consecutive", 8'(pops), 8'd5);
        drain();
        // Asynchronous reset with three beats in flight.
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) drive(8'hF0, 3'd1, 1'b0, 2'd0, '{8'h78, 1'b0});
        check("prereset_out_valid", {7'b0, out_valid}, 8'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", {7'b0, out_valid}, 8'd0);
        check("async_rst_data", out_data, 8'h00);
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("post_rst_no_beat", {7'b0, out_valid}, 8'd0);
        end
        @(posedge clk);
        #1;
        // Random ops, amounts and stalls against the reference model.
        sent = 0;
        have = 1'b0;
        for (int c = 0; c < 60000 && sent < 10000; c++) begin
            out_ready = $urandom_range(0, 3) != 0;
            if (!have && $urandom_range(0, 4) != 0) begin
                in_data = $urandom_range(0, 7) == 0 ? 8'h00 : 8'($urandom);
                in_shamt = 3'($urandom_range(0, 7));
                in_dir = 1'($urandom_range(0, 1));
                in_op = 2'($urandom_range(0, 3));
                cur_exp = model(in_data, int'(in_shamt), in_dir, in_op);
                have = 1'b1;
            end
            in_valid = have;
            @(negedge clk);
            if (in_valid && in_ready) begin
                have = 1'b0;
                sent++;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("random_all_sent", 8'(sent == 10000), 8'd1);
        drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pipelined_barrel_shifter.md
# pipelined_barrel_shifter

Parametrised, pipelined barrel shifter with a valid/ready handshake. It is the datapath successor to the 4-bit combinational shifter. It supports logical shift, rotate, arithmetic shift and pass-through in either direction on a WIDTH-bit operand. The block decomposes the shift amount into log2(WIDTH) registered stages and sits between an upstream producer and a downstream consumer, both of which may stall.

## Interface
Parameters:
- WIDTH, 8, operand width; power of two, at least 4.
- SH_W, $clog2(WIDTH), shift-amount width; derived, do not override.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  the input beat is valid.
- in_ready  out  1  the block accepts the input beat this cycle.
- in_data  in  WIDTH  operand.
- in_shamt  in  SH_W  shift amount, 0 to WIDTH-1.
- in_dir  in  1  0 = right, 1 = left.
- in_op  in  2  operation; see Operation.
- out_valid  out  1  the result beat is valid.
- out_ready  in  1  the consumer accepts the result beat.
- out_data  out  WIDTH  result.
- out_carry  out  1  last bit shifted out; present only with BARREL_SHIFTER_FLAGS_EN.
- out_zero  out  1  out_data == 0; present only with BARREL_SHIFTER_FLAGS_EN.

## Operation
- in_op encoding:
  - 00 LSL/LSR: logical shift, zero fill.
  - 01 ROT: rotate.
  - 10 ASH: right direction sign-fills from in_data[WIDTH-1]; left direction behaves exactly as logical.
  - 11 PASS: out_data = in_data, carry 0; in_shamt and in_dir are ignored.
- The pipeline has SH_W stages. Stage k (k = 0 .. SH_W-1) applies a shift of 2^k when shamt bit k is 1; otherwise it passes the data through. Each stage registers data, the remaining control fields, a valid bit and a carry.
- in_shamt = 0 gives out_data = in_data and carry 0 for every op.
- Fill bits:
  - Logical: 0.
  - Rotate: the wrapped bits.
  - Arithmetic: copies of the original sign bit, carried with the beat.
- Carry rule:
  - Each active stage sets carry to the last bit it shifts out: intermediate bit 2^k-1 for right, bit WIDTH-2^k for left.
  - An inactive stage holds carry.
  - The final carry therefore equals original bit s-1 for a right shift and bit WIDTH-s for a left shift, where s is the shift amount.
  - Rotate uses the same index, i.e. the last bit that wrapped.
- Handshake:
  - A beat transfers on in_valid && in_ready.
  - A result is consumed on out_valid && out_ready.
  - Stage k advances when its slot is empty or stage k+1 advances. Ready chains combinationally: rdy[k] = !vld[k] || rdy[k+1], and rdy[SH_W] = out_ready.
  - in_ready = rdy[0].
- Bubbles collapse: an empty stage accepts new data even while the output is stalled.
- While out_valid && !out_ready, out_data, out_carry and out_zero are held stable.
- Valid bits are cleared by reset. Data registers need not be reset, but out_data must read 0 after reset.

## Timing
- Latency is SH_W cycles from an accepted input to out_valid, with no stalls. For WIDTH = 8 the latency is 3.
- Throughput is one beat per cycle under continuous out_ready.
- Capacity is SH_W beats in flight.
- When full and out_ready = 0, in_ready = 0 in the same cycle.
- A simultaneous pop and push when full is allowed: in_ready = 1 in that cycle and there is no bubble.
- All outputs reset to 0: out_valid, out_data, out_carry and out_zero.
- Reset asserted mid-operation discards every in-flight beat immediately (asynchronously). No partial result is emitted after rst_n deasserts.
- in_ready is combinational from out_ready and the valid bits. There is no combinational path from in_* to out_*.

## Configuration
- BARREL_SHIFTER_FLAGS_EN defined:
  - out_carry and out_zero ports exist.
  - A carry register exists per stage.
  - out_zero is registered alongside the final stage.
- Not defined:
  - Both ports and all carry logic are absent.
  - Data and handshake behaviour are identical.

## Structure
- Package barrel_shifter_pkg holds:
  - typedef enum logic [1:0] shift_op_e with SH_LOGIC = 0, SH_ROT = 1, SH_ARITH = 2, SH_PASS = 3.
  - Localparams DIR_RIGHT = 0 and DIR_LEFT = 1.
- Sub-module shift_stage (parameters WIDTH and STAGE) is the one registered 2^STAGE shift stage, including its valid/ready slot. The top level instantiates it SH_W times in a generate loop.

## Test plan
- WIDTH=8, in_data=0x96, LSL (op 00, dir 1), shamt 3 -> after 3 cycles out_data=0xB0, out_carry=0.
- in_data=0x96, LSR (op 00, dir 0), shamt 2 -> out_data=0x25, out_carry=1. ROT right shamt 1 -> 0x4B. ASH right shamt 2 -> 0xE5.
- shamt 0 for all four ops on 0xA5 -> 0xA5 with carry 0. PASS with shamt 7 -> 0xA5.
- Backpressure: stream 5 beats while out_ready=0 -> exactly 3 beats are accepted, then in_ready=0 and out_data is held. Raise out_ready -> all 5 results emerge in order, one per cycle.
- Random ops, amounts and stalls over 10k beats, checked against a reference model -> zero mismatches; out_zero=1 exactly when out_data=0.
- Assert rst_n low with 3 beats in flight -> out_valid=0 and out_data=0 immediately; no stale beat appears after release.
